// File: rtl/fetch_pkg.sv
// Shared widths, types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] instr_t;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;
  localparam logic [ADDR_W-1:0] PC_INC       = ADDR_W'(4);
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-2 FIFO with flush; flush wins over push/pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: credit-based imem requests, in-order responses into a prefetch
// queue, redirect flush with discard of responses still in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  instr_t            imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output instr_t            instr_data,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     outstanding, discard, occ, tag_cnt;
  logic [CW+1:0]     inflight;
  logic              fire, resp_live, pop;
  logic              q_empty, q_full, tag_empty, tag_full;
  logic [ADDR_W-1:0] tag_pc;
  logic [QW-1:0]     q_head;

  // Every slot that could still be filled is reserved before a request goes out,
  // so an accepted response can never find the queue full.
  assign inflight       = (CW+2)'(occ) + (CW+2)'(outstanding) + (CW+2)'(discard);
  assign imem_req_valid = !reset && !redirect_valid && (inflight < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign resp_live      = imem_resp_valid && (discard == '0) && !redirect_valid;

  assign instr_valid = !q_empty;
  assign pop         = instr_valid && instr_ready;
  assign instr_pc    = instr_valid ? q_head[QW-1:DATA_W] : '0;
  assign instr_data  = instr_valid ? q_head[DATA_W-1:0]  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= {RESET_PC[ADDR_W-1:2], 2'b00};
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything in flight becomes garbage; a response this cycle retires one of them.
      fetch_pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
      discard     <= discard + outstanding - CW'(imem_resp_valid);
      outstanding <= '0;
    end else begin
      if (fire) fetch_pc <= fetch_pc + PC_INC;
      outstanding <= outstanding + CW'(fire) - CW'(resp_live);
      if (imem_resp_valid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_tag (
    .clk   (clk),
    .reset (reset),
    .push  (fire),
    .pop   (resp_live),
    .flush (redirect_valid),
    .din   (fetch_pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_cnt)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(QW)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (resp_live),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({tag_pc, imem_resp_data}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (occ)
  );

`ifndef SYNTHESIS
  a_resp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> ((outstanding + discard) != '0));
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (imem_req_valid && !imem_req_ready) |=> $stable(imem_req_addr));
  a_tag_track: assert property (@(posedge clk) disable iff (reset)
    (tag_cnt == outstanding) && (tag_empty == (outstanding == '0)));
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (reset)
    !(tag_full && fire && !resp_live));
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(q_full && resp_live && !pop));
`endif
endmodule
